// File: rtl/cla_add32_pipe_if.sv
// Operand/result handshake bundle for cla_add32_pipe.
// The master side offers operands and consumes results; the adder sits on the slave side.
interface cla_add32_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_c;
  logic        out_v;
  logic        out_z;
  logic        out_n;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
  );
endinterface

// File: rtl/cla_add32_pipe.sv
// Two-stage 32-bit carry-lookahead add/sub: stage 1 registers bit/group P,G; stage 2 resolves carries.
// Define CLA_ADD_FLAGS_EN to compute the c/v/z/n flags; otherwise the flag outputs are tied 0.
module cla_add32_pipe (
  input  logic             clk,
  input  logic             rst,
  cla_add32_pipe_if.slave  bus
);

  // Handshake: a beat transfers on an edge where valid && ready are both high; an
  // unaccepted result holds its data and valid until ready is seen.
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_en;
  logic s1_en;
  logic accept;

  assign s2_en        = !out_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Carry into slice k as one flat sum of products over the group signals of slices below it.
  function automatic logic carry_into(input int k, input logic [7:0] gp, input logic [7:0] gg,
                                      input logic c0);
    logic c;
    logic prod;
    c    = 1'b0;
    prod = 1'b1;
    for (int j = k - 1; j >= 0; j--) begin
      c    = c | (prod & gg[j]);
      prod = prod & gp[j];
    end
    return c | (prod & c0);
  endfunction

  logic [31:0] bx_d;
  logic [31:0] p_d;
  logic [31:0] g_d;
  logic [7:0]  gp_d;
  logic [7:0]  gg_d;

  always_comb begin
    bx_d = bus.in_sub ? ~bus.in_b : bus.in_b;
    p_d  = bus.in_a ^ bx_d;
    g_d  = bus.in_a & bx_d;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < 8; k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  logic [31:0]     p_q;
  logic [7:0][2:0] g_q;   // top generate bit of each slice only feeds the group term
  logic [7:0]      gp_q;
  logic [7:0]      gg_q;
  logic            c0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_q  <= p_d;
      gp_q <= gp_d;
      gg_q <= gg_d;
      c0_q <= bus.in_sub;
      for (int k = 0; k < 8; k++) begin
        g_q[k] <= g_d[4*k +: 3];
      end
    end
  end

  logic [7:0]  gc;
  logic [31:0] cb;
  logic [31:0] sum_d;

  always_comb begin
    gc = '0;
    cb = '0;
    for (int k = 0; k < 8; k++) begin
      gc[k]      = carry_into(k, gp_q, gg_q, c0_q);
      cb[4*k]    = gc[k];
      cb[4*k+1]  = g_q[k][0] | (p_q[4*k] & gc[k]);
      cb[4*k+2]  = g_q[k][1] | (p_q[4*k+1] & g_q[k][0])
                 | (p_q[4*k+1] & p_q[4*k] & gc[k]);
      cb[4*k+3]  = g_q[k][2] | (p_q[4*k+2] & g_q[k][1])
                 | (p_q[4*k+2] & p_q[4*k+1] & g_q[k][0])
                 | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & gc[k]);
    end
    sum_d = p_q ^ cb;
  end

  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q <= sum_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;

`ifdef CLA_ADD_FLAGS_EN
  logic a31_q;
  logic b31_q;
  logic c_q;
  logic v_q;
  logic z_q;
  logic n_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      a31_q <= bus.in_a[31];
      b31_q <= bx_d[31];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (s2_en && s1_valid_q) begin
      c_q <= carry_into(8, gp_q, gg_q, c0_q);
      v_q <= (a31_q == b31_q) && (sum_d[31] != a31_q);
      z_q <= (sum_d == 32'd0);
      n_q <= sum_d[31];
    end
  end

  assign bus.out_c = c_q;
  assign bus.out_v = v_q;
  assign bus.out_z = z_q;
  assign bus.out_n = n_q;
`else
  assign bus.out_c = 1'b0;
  assign bus.out_v = 1'b0;
  assign bus.out_z = 1'b0;
  assign bus.out_n = 1'b0;
`endif

endmodule

// File: doc/cla_add32_pipe.md
# cla_add32_pipe

Two-stage pipelined 32-bit adder/subtractor for the RICS execute stage. It is built from eight 4-bit carry-lookahead slices, each producing group propagate/generate. A second-level lookahead unit consumes those group signals to form all slice carry-ins in one level. Operands enter and results leave over valid/ready handshakes, with full back-pressure and one result per cycle sustained throughput.

## Interface
- Parameters: none; width is fixed at 32 (eight 4-bit slices).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  32  result, modulo 2^32.
- out_c  out  1  carry out of bit 31 (for subtract, 1 = no borrow).
- out_v  out  1  signed overflow.
- out_z  out  1  out_sum == 0.
- out_n  out  1  out_sum[31].

## Operation
- Accept on in_valid && in_ready; drain on out_valid && out_ready.
- Stage 1 (accept edge):
  - registers B' = in_sub ? ~in_b : in_b, c0 = in_sub, A, and A[31]/B'[31] for overflow;
  - registers per-bit P = A^B', G = A&B';
  - registers per-slice group p_k = &P[4k+3:4k] and g_k (standard 4-bit lookahead), k = 0..7.
- Stage 2 (advance edge):
  - slice carry-ins c_k from c0 and registered p/g: c_{k+1} = g_k | p_k&c_k, expanded as a flat two-level lookahead, no ripple across slices;
  - intra-slice carries use the 4-bit lookahead equations;
  - sum = P ^ carries; out_c = c_8; out_v = (A31 == B'31) && (sum31 != A31).
  - All result outputs are registered.
- Enables:
  - s2_en = !out_valid || out_ready;
  - s1_en = !s1_valid || s2_en;
  - in_ready = s1_en && !rst.
- Stalled stages hold data and valid unchanged. Output data is stable while out_valid && !out_ready.
- No FSM. State is s1_valid, out_valid, and the data registers.

## Timing
- Reset: s1_valid=0, out_valid=0, out_sum=0, out_c=out_v=out_z=out_n=0. in_ready=0 while rst is high, 1 in the first cycle after.
- Reset mid-operation discards both stages at that edge. A beat offered during rst is not accepted.
- Latency: beat accepted at edge T has out_valid=1 after edge T+1 when no stall.
- Throughput: 1 beat/cycle with out_ready held 1.
- Full pipeline (s1_valid && out_valid && !out_ready): in_ready=0.
- in_ready depends combinationally on out_ready; no other in→out combinational paths.
- Simultaneous drain and refill in the same cycle is legal at both stages, with no bubble.

## Configuration
- CLA_ADD_FLAGS_EN defined:
  - out_c, out_v, out_z, out_n computed and registered as above.
- Not defined:
  - flag ports remain present but are tied 0;
  - overflow and zero logic and their stage-1 registers are omitted;
  - sum, handshake and latency are unchanged.

## Test plan
- Reset, then add 0x0000_0001 + 0xFFFF_FFFF, sub=0:
  - out_valid at T+2, sum=0x0000_0000;
  - c=1, z=1, v=0, n=0 (flags macro defined).
- Add 0x7FFF_FFFF + 0x0000_0001:
  - sum=0x8000_0000, v=1, n=1, c=0.
- Subtract 5 - 7:
  - sum=0xFFFF_FFFE, c=0, n=1, v=0.
- Subtract 0x8000_0000 - 1:
  - sum=0x7FFF_FFFF, v=1, c=1.
- Streaming with back-pressure:
  - stimulus: 8 back-to-back beats (i + 0x0F0F_0F0F·i), out_ready held 0 for 3 cycles mid-stream;
  - response: in_ready drops only when both stages are full; all 8 results in order, none duplicated or lost; out_sum stable during stall.
- Reset mid-operation:
  - stimulus: rst pulsed with both stages full;
  - response: next cycle out_valid=0 and outputs 0; no stale result emerges; first post-reset beat returns after 2 cycles.
- Random 10k beats with random in_valid/out_ready against a reference sum, both macro settings:
  - with macro undefined, flags remain 0.
